// File: rtl/resp_capture_misr_if.sv
// Capture/readout bundle for the response MISR.
// master drives the run controls and the sampled bus.
interface resp_capture_misr_if #(
  parameter int WIDTH     = 117,
  parameter int SIG_WIDTH = 32
);
  logic                 start;
  logic [15:0]          num_samples;
  logic [WIDTH-1:0]     y;
  logic                 rd_start;
  logic                 busy;
  logic                 done;
  logic [SIG_WIDTH-1:0] signature;
  logic [15:0]          sample_cnt;
  logic                 sout;
  logic                 sout_valid;

  modport master (
    output start, num_samples, y, rd_start,
    input  busy, done, signature,
    input  sample_cnt, sout, sout_valid
  );

  modport slave (
    input  start, num_samples, y, rd_start,
    output busy, done, signature,
    output sample_cnt, sout, sout_valid
  );
endinterface

// File: rtl/resp_capture_misr.sv
// Compresses a wide response bus into a MISR signature
// and shifts the final signature out MSB first.
module resp_capture_misr #(
  parameter int WIDTH     = 117,
  parameter int SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED = 32'hFFFFFFFF
) (
  input logic               clk,
  input logic               rst,
  resp_capture_misr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, CAPTURE, DONE, SHIFT
  } state_t;

  localparam int NCH = (WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PW  = NCH * SIG_WIDTH;
  localparam int BW  = $clog2(SIG_WIDTH + 1);

  state_t               state, state_nxt;
  logic [SIG_WIDTH-1:0] sig, shreg, fold, stepped;
  logic [15:0]          cnt, n, cnt_inc;
  logic [BW-1:0]        bitcnt;
  logic                 sout, sout_valid;
  logic                 busy, done;
  logic [PW-1:0]        ypad;
  logic                 go, rd, last, last_bit;

  assign ypad = PW'(bus.y);

  always_comb begin
    fold = '0;
    for (int k = 0; k < NCH; k++)
      fold = fold ^ ypad[k*SIG_WIDTH +: SIG_WIDTH];
  end

  assign stepped = {sig[SIG_WIDTH-2:0], 1'b0}
                 ^ (sig[SIG_WIDTH-1] ? POLY : '0);

  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign go       = (state == IDLE || state == DONE)
                  && bus.start;
  // start outranks rd_start when both arrive in DONE
  assign rd       = (state == DONE) && bus.rd_start
                  && !bus.start;
  assign last     = (cnt_inc == n);
  assign last_bit = (bitcnt == BW'(SIG_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (go)
          state_nxt = (bus.num_samples == 16'd0)
                    ? DONE : CAPTURE;
        else if (rd)
          state_nxt = SHIFT;
      end
      CAPTURE: if (last)     state_nxt = DONE;
      SHIFT:   if (last_bit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CAPTURE) || (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig        <= SEED;
      cnt        <= '0;
      n          <= '0;
      shreg      <= '0;
      bitcnt     <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            n   <= bus.num_samples;
            sig <= SEED;
            cnt <= '0;
          end else if (rd) begin
            shreg      <= {sig[SIG_WIDTH-2:0], 1'b0};
            sout       <= sig[SIG_WIDTH-1];
            sout_valid <= 1'b1;
            bitcnt     <= BW'(1);
          end
        end
        CAPTURE: begin
          sig <= stepped ^ fold;
          cnt <= cnt_inc;
        end
        SHIFT: begin
          if (last_bit) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            bitcnt     <= '0;
          end else begin
            sout   <= shreg[SIG_WIDTH-1];
            shreg  <= {shreg[SIG_WIDTH-2:0], 1'b0};
            bitcnt <= bitcnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.signature  = sig;
  assign bus.sample_cnt = cnt;
  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;

endmodule

// File: tb/tb_resp_capture_misr.sv
// Directed bench for resp_capture_misr: capture runs,
// fold checks, serial readout and reset recovery.
module tb_resp_capture_misr;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  resp_capture_misr_if #(.WIDTH(117), .SIG_WIDTH(32)) bus();

  resp_capture_misr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mstep(logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
  endfunction

  // bitwise fold: bit i of y lands on signature bit i mod 32
  function automatic logic [31:0] mfold(logic [116:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 117; i++)
      f[i % 32] = f[i % 32] ^ v[i];
    return f;
  endfunction

  task automatic run1(input logic [116:0] v);
    bus.start = 1'b1;
    bus.num_samples = 16'd1;
    tick();
    bus.start = 1'b0;
    bus.y = v;
    tick();
  endtask

  logic [116:0] vec [4];
  logic [31:0]  model;
  logic [31:0]  rec;
  int           nvalid;

  initial begin
    vec[0] = 117'h1F_0123_4567_89AB_CDEF_FEDC_BA98_7654;
    vec[1] = 117'h0A_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC;
    vec[2] = 117'h15_5555_AAAA_3333_CCCC_0F0F_F0F0_8001;
    vec[3] = 117'h00_0000_0001_8000_0000_FFFF_0000_0003;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.rd_start = 1'b0;
    bus.num_samples = 16'd0;
    bus.y = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_sig", bus.signature, SEED);
    chk("rst_cnt", 32'(bus.sample_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sout", 32'(bus.sout), 32'd0);
    chk("rst_sv", 32'(bus.sout_valid), 32'd0);

    // N = 0 goes straight to DONE
    bus.start = 1'b1;
    bus.num_samples = 16'd0;
    tick();
    bus.start = 1'b0;
    chk("n0_done", 32'(bus.done), 32'd1);
    chk("n0_busy", 32'(bus.busy), 32'd0);
    chk("n0_sig", bus.signature, SEED);
    chk("n0_cnt", 32'(bus.sample_cnt), 32'd0);
    tick();
    chk("n0_busy2", 32'(bus.busy), 32'd0);

    // N = 1, y = 0
    bus.start = 1'b1;
    bus.num_samples = 16'd1;
    tick();
    chk("n1_busy", 32'(bus.busy), 32'd1);
    chk("n1_ndone", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    bus.y = '0;
    tick();
    chk("n1_sig", bus.signature, 32'hFB3EE249);
    chk("n1_cnt", 32'(bus.sample_cnt), 32'd1);
    chk("n1_done", 32'(bus.done), 32'd1);
    chk("n1_busy0", 32'(bus.busy), 32'd0);

    // serial readout of FB3EE249
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    chk("rd_sv0", 32'(bus.sout_valid), 32'd1);
    chk("rd_done0", 32'(bus.done), 32'd0);
    chk("rd_busy0", 32'(bus.busy), 32'd1);
    rec = '0;
    rec[31] = bus.sout;
    nvalid = 1;
    for (int i = 1; i < 32; i++) begin
      tick();
      rec[31-i] = bus.sout;
      nvalid += int'(bus.sout_valid);
    end
    chk("rd_first8", 32'(rec[31:24]), 32'hFB);
    chk("rd_bits", rec, 32'hFB3EE249);
    chk("rd_nvalid", nvalid, 32'd32);
    tick();
    chk("rd_sv_end", 32'(bus.sout_valid), 32'd0);
    chk("rd_sout_end", 32'(bus.sout), 32'd0);
    chk("rd_done_end", 32'(bus.done), 32'd1);
    chk("rd_sig_hold", bus.signature, 32'hFB3EE249);

    // start and rd_start together: start wins
    bus.start = 1'b1;
    bus.rd_start = 1'b1;
    bus.num_samples = 16'd1;
    tick();
    bus.start = 1'b0;
    bus.rd_start = 1'b0;
    chk("both_busy", 32'(bus.busy), 32'd1);
    chk("both_sv", 32'(bus.sout_valid), 32'd0);
    bus.y = 117'h1;
    tick();
    chk("fold_lo", bus.signature, 32'hFB3EE248);

    run1(117'h1 << 32);
    chk("fold_c1", bus.signature, 32'hFB3EE248);

    run1(117'h1 << 116);
    chk("fold_top", bus.signature, 32'hFB2EE249);

    // N = 4 against the model, with a stray start
    model = SEED;
    for (int i = 0; i < 4; i++)
      model = mstep(model) ^ mfold(vec[i]);
    bus.start = 1'b1;
    bus.num_samples = 16'd4;
    tick();
    bus.start = 1'b0;
    bus.y = vec[0];
    tick();
    chk("n4_cnt1", 32'(bus.sample_cnt), 32'd1);
    bus.y = vec[1];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("n4_busy", 32'(bus.busy), 32'd1);
    bus.y = vec[2];
    tick();
    bus.y = vec[3];
    tick();
    chk("n4_cnt", 32'(bus.sample_cnt), 32'd4);
    chk("n4_done", 32'(bus.done), 32'd1);
    chk("n4_sig", bus.signature, model);

    // reset at sample 2 of an N = 10 run
    bus.start = 1'b1;
    bus.num_samples = 16'd10;
    tick();
    bus.start = 1'b0;
    bus.y = vec[0];
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstc_sig", bus.signature, SEED);
    chk("rstc_cnt", 32'(bus.sample_cnt), 32'd0);
    chk("rstc_busy", 32'(bus.busy), 32'd0);
    chk("rstc_done", 32'(bus.done), 32'd0);

    // reset at bit 5 of a readout
    run1('0);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rsts_sv_pre", 32'(bus.sout_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsts_sv", 32'(bus.sout_valid), 32'd0);
    chk("rsts_sout", 32'(bus.sout), 32'd0);
    chk("rsts_sig", bus.signature, SEED);
    chk("rsts_cnt", 32'(bus.sample_cnt), 32'd0);
    chk("rsts_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("rsts_idle", 32'(bus.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/resp_capture_misr.md
# resp_capture_misr

Response-side companion to the stimulus bench. It samples the 117-bit `y` output of the synthesized `top` once per clock for a programmed number of cycles. It compresses the samples into a 32-bit multiple-input signature register (MISR) and shifts the final signature out serially. This lets equivalence runs compare a single signature instead of diffing a `$strobe` log.

## Interface

Parameters:
- `WIDTH`, 117: width of the captured response bus.
- `SIG_WIDTH`, 32: signature width.
- `POLY`, 32'h04C11DB7: Galois feedback polynomial (bit i set means tap on bit i).
- `SEED`, 32'hFFFFFFFF: signature value loaded on reset and on `start`.

Ports:
- `clk`, input, 1: single clock; all state changes on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a capture run; honoured only in IDLE or DONE.
- `num_samples`, input, 16: number of `y` samples to compress; latched on `start`.
- `y`, input, WIDTH: DUT response bus.
- `rd_start`, input, 1: begin serial readout; honoured only in DONE.
- `busy`, output, 1: high in CAPTURE and SHIFT.
- `done`, output, 1: high in DONE.
- `signature`, output, SIG_WIDTH: current MISR contents.
- `sample_cnt`, output, 16: samples absorbed in the current run.
- `sout`, output, 1: serial signature bit, MSB first.
- `sout_valid`, output, 1: high while `sout` carries a valid bit.

## Operation

- States are IDLE, CAPTURE, DONE and SHIFT.
- On reset, the block enters IDLE with these output values:
  - `signature` = SEED
  - `sample_cnt` = 0
  - `busy` = 0
  - `done` = 0
  - `sout` = 0
  - `sout_valid` = 0
  - the internal shift register is cleared.
- Fold: `y` is zero-padded to a multiple of SIG_WIDTH and split into chunks, with chunk k = bits [k*SIG_WIDTH +: SIG_WIDTH]. `fold` is the XOR of all chunks. For WIDTH=117 that is 4 chunks, with the top 11 bits of chunk 3 zero.
- Step: `step(s) = {s[SIG_WIDTH-2:0],1'b0} ^ (s[SIG_WIDTH-1] ? POLY : 0)`.
- Per sample: `signature <= step(signature) ^ fold(y)`, and `sample_cnt` increments.
- IDLE/DONE with `start`:
  - latch `num_samples` as N, load `signature` = SEED and clear `sample_cnt`.
  - if N == 0, go to DONE directly (signature stays SEED).
  - otherwise go to CAPTURE.
- CAPTURE:
  - every cycle, absorb the `y` present at that posedge.
  - on the edge that absorbs sample N, go to DONE.
  - `start` and `rd_start` are ignored.
- DONE:
  - `signature` and `sample_cnt` hold.
  - `rd_start` copies `signature` into the shift register and goes to SHIFT.
  - if `start` and `rd_start` are both high, `start` wins.
- SHIFT:
  - each cycle, `sout` = shift register MSB and `sout_valid` = 1, then the register shifts left.
  - after SIG_WIDTH bits, go to DONE.
  - `start` and `rd_start` are ignored.
  - `signature` is not modified.
- `sample_cnt` saturates at 16'hFFFF. It cannot exceed N; N = 65535 is legal.
- Reset asserted in any state, mid-capture or mid-shift, returns to IDLE with the reset values above on the next edge. A partial signature is discarded.

## Timing

- `start` sampled at edge T0: `busy` = 1 from T0. The first sample is the `y` present at edge T1, and `signature` reflects it after T1.
- Sample N is absorbed at edge TN. `busy` = 0 and `done` = 1 after TN.
- A run takes exactly N+1 edges from `start` to `done`.
- `rd_start` sampled at edge R0: `sout_valid` is high for the SIG_WIDTH cycles following R0. Bit SIG_WIDTH-1 is valid after R0 and bit 0 after R0+SIG_WIDTH-1. `done` drops during SHIFT and returns after R0+SIG_WIDTH.
- `sout` = 0 whenever `sout_valid` = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- `start` in DONE restarts immediately, with the same latency as from IDLE.

## Test plan

- Reset then `start` with N=0 -> `done`=1 one edge later, `signature`=32'hFFFFFFFF, `sample_cnt`=0, `busy` never observed high after that edge.
- `start` with N=1 and `y`=0 -> after 2 edges `signature`=32'hFB3EE249, `sample_cnt`=1, `done`=1.
- N=1 with `y`=117'h1, then again with `y`=117'h1<<32 -> both give `signature`=32'hFB3EE248, checking the fold.
- N=4 driving the bench's first four 117-bit vectors -> `signature` matches the bench's reference model of fold/step. Pulse `start` mid-run -> ignored, `sample_cnt` still ends at 4.
- From DONE with 32'hFB3EE249, pulse `rd_start` -> 32 cycles of `sout_valid`, first bits 1,1,1,1,1,0,1,1, last bit 1, then `done`=1 and `signature` unchanged.
- Assert `rst` at sample 2 of an N=10 run, and separately at bit 5 of a readout -> next edge shows IDLE with `signature`=SEED, `sample_cnt`=0, `sout_valid`=0.
